// File: rtl/overlapping_template_stimulus.sv
// Stimulus source for the overlapping-template test: N blocks of M bits, each opening
// with exactly k runs of the all-ones template and filled out with LFSR bits.
module overlapping_template_stimulus #(
    parameter int M = 1032,
    parameter int N = 1000,
    parameter int m = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_mode,
    input  logic [2:0]  i_k_cfg,
    input  logic [15:0] i_seed,
    input  logic        i_ready,
    output logic        o_rand,
    output logic        o_valid,
    output logic        o_block_start,
    output logic        o_block_end,
    output logic        o_busy,
    output logic        o_done
);
    localparam int BW = (M > 1) ? $clog2(M) : 1;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [3:0]    RUN_MAX  = 4'(m - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(M - 1);
    localparam logic [KW-1:0] LAST_BLK = KW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_n;
    logic [BW-1:0] r_bit_idx;
    logic [KW-1:0] r_blk_idx;
    logic [2:0]    r_kmod;
    logic [2:0]    r_kcfg;
    logic          r_mode;
    logic [3:0]    r_ones;
    logic [3:0]    r_mod10;
    logic [15:0]   r_lfsr;
    logic          r_rand;
    logic          r_valid;
    logic          r_bstart;
    logic          r_bend;
    logic          r_busy;
    logic          r_done;

    logic          w_load;
    logic          w_accept;
    logic          w_last_bit;
    logic          w_last_blk;
    logic          w_in_rand;
    logic [2:0]    w_k;
    logic [2:0]    w_k_n;
    logic [15:0]   w_seed;
    logic [BW-1:0] w_adv_idx;
    logic [KW-1:0] w_adv_blk;
    logic [2:0]    w_adv_kmod;
    logic [3:0]    w_adv_ones;
    logic [3:0]    w_adv_mod10;
    logic [15:0]   w_adv_lfsr;
    logic          w_rand_n;
    logic          w_valid_n;
    logic          w_bstart_n;
    logic          w_bend_n;

    // x^16+x^14+x^13+x^11+1, shifting right with the feedback entering bit 15
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        lfsr_step = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic logic in_pattern(input logic [BW-1:0] idx, input logic [2:0] k);
        in_pattern = (32'(idx) < (32'(k) * 32'd10));
    endfunction

    // Value of the bit at idx; the ones-run cap keeps random runs one short of the template
    function automatic logic bit_value(input logic [BW-1:0] idx, input logic [2:0] k,
                                       input logic [3:0] mod10, input logic [3:0] ones,
                                       input logic [15:0] lfsr);
        if (idx == LAST_BIT) begin
            bit_value = 1'b0;
        end else if (in_pattern(idx, k)) begin
            bit_value = (mod10 != 4'd9);
        end else if (ones == RUN_MAX) begin
            bit_value = 1'b0;
        end else begin
            bit_value = lfsr[0];
        end
    endfunction

    assign w_load     = (r_state == S_IDLE) && i_start;
    assign w_accept   = (r_state == S_RUN) && r_valid && i_ready;
    assign w_last_bit = (r_bit_idx == LAST_BIT);
    assign w_last_blk = (r_blk_idx == LAST_BLK);
    assign w_k        = r_mode ? r_kmod : r_kcfg;
    assign w_k_n      = r_mode ? w_adv_kmod : r_kcfg;
    assign w_in_rand  = !w_last_bit && !in_pattern(r_bit_idx, w_k);
    assign w_seed     = (i_seed == 16'h0000) ? 16'h0001 : i_seed;

    // Counter values for the bit that follows the one currently presented
    always_comb begin
        if (w_last_bit) begin
            w_adv_idx   = BW'(0);
            w_adv_blk   = r_blk_idx + KW'(1);
            w_adv_kmod  = (r_kmod == 3'd5) ? 3'd0 : r_kmod + 3'd1;
            w_adv_ones  = 4'd0;
            w_adv_mod10 = 4'd0;
        end else begin
            w_adv_idx   = r_bit_idx + BW'(1);
            w_adv_blk   = r_blk_idx;
            w_adv_kmod  = r_kmod;
            w_adv_ones  = r_rand ? r_ones + 4'd1 : 4'd0;
            w_adv_mod10 = (r_mod10 == 4'd9) ? 4'd0 : r_mod10 + 4'd1;
        end
        w_adv_lfsr = w_in_rand ? lfsr_step(r_lfsr) : r_lfsr;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next-state logic
    always_comb begin
        case (r_state)
            S_IDLE:  w_state_n = i_start ? S_RUN : S_IDLE;
            S_RUN:   w_state_n = (w_accept && w_last_bit && w_last_blk) ? S_DONE : S_RUN;
            S_DONE:  w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    // Output logic, evaluated for the state being entered so the outputs can be registered
    always_comb begin
        w_valid_n  = 1'b0;
        w_rand_n   = 1'b0;
        w_bstart_n = 1'b0;
        w_bend_n   = 1'b0;
        if (w_state_n == S_RUN) begin
            if (w_load) begin
                w_valid_n  = 1'b1;
                w_rand_n   = bit_value(BW'(0), i_mode ? 3'd0 : i_k_cfg, 4'd0, 4'd0, w_seed);
                w_bstart_n = 1'b1;
                w_bend_n   = (LAST_BIT == BW'(0));
            end else if (w_accept) begin
                w_valid_n  = 1'b1;
                w_rand_n   = bit_value(w_adv_idx, w_k_n, w_adv_mod10, w_adv_ones, w_adv_lfsr);
                w_bstart_n = (w_adv_idx == BW'(0));
                w_bend_n   = (w_adv_idx == LAST_BIT);
            end else begin
                w_valid_n  = r_valid;
                w_rand_n   = r_rand;
                w_bstart_n = r_bstart;
                w_bend_n   = r_bend;
            end
        end else begin
            w_valid_n = 1'b0;
        end
    end

    // Run context: latched on start, stepped on each accepted bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_idx <= BW'(0);
            r_blk_idx <= KW'(0);
            r_kmod    <= 3'd0;
            r_kcfg    <= 3'd0;
            r_mode    <= 1'b0;
            r_ones    <= 4'd0;
            r_mod10   <= 4'd0;
            r_lfsr    <= 16'h0000;
        end else if (w_load) begin
            r_bit_idx <= BW'(0);
            r_blk_idx <= KW'(0);
            r_kmod    <= 3'd0;
            r_kcfg    <= i_k_cfg;
            r_mode    <= i_mode;
            r_ones    <= 4'd0;
            r_mod10   <= 4'd0;
            r_lfsr    <= w_seed;
        end else if (w_accept) begin
            r_bit_idx <= w_adv_idx;
            r_blk_idx <= w_adv_blk;
            r_kmod    <= w_adv_kmod;
            r_ones    <= w_adv_ones;
            r_mod10   <= w_adv_mod10;
            r_lfsr    <= w_adv_lfsr;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rand   <= 1'b0;
            r_valid  <= 1'b0;
            r_bstart <= 1'b0;
            r_bend   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_rand   <= w_rand_n;
            r_valid  <= w_valid_n;
            r_bstart <= w_bstart_n;
            r_bend   <= w_bend_n;
            r_busy   <= (w_state_n == S_RUN);
            r_done   <= (w_state_n == S_DONE);
        end
    end

    assign o_rand        = r_rand;
    assign o_valid       = r_valid;
    assign o_block_start = r_bstart;
    assign o_block_end   = r_bend;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

endmodule

// File: doc/overlapping_template_stimulus.md
OVERLAPPING_TEMPLATE_STIMULUS -- requirements
Module: overlapping_template_stimulus

Interface
REQ-001 Parameter M, default 1032, bits per block.
REQ-002 Parameter N, default 1000, blocks per run.
REQ-003 Parameter m, default 9, template length; template is all ones.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  begin a run; sampled only in IDLE.
REQ-007 mode  input  1  0: fixed k per block; 1: k = block index mod 6.
REQ-008 k_cfg  input  3  template occurrences per block when mode=0; range 0..7.
REQ-009 seed  input  16  LFSR seed, loaded on accepted start.
REQ-010 ready  input  1  consumer accepts the current bit this cycle.
REQ-011 rand  output  1  stream bit.
REQ-012 valid  output  1  rand is meaningful.
REQ-013 block_start  output  1  high while the current bit is bit 0 of a block.
REQ-014 block_end  output  1  high while the current bit is bit M-1 of a block.
REQ-015 busy  output  1  high in RUN.
REQ-016 done  output  1  one-cycle pulse after the last bit of block N-1 is accepted.

Function
REQ-017 States IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE when bit M-1 of block N-1 is accepted, DONE->IDLE unconditionally after one cycle.
REQ-018 On accepted start: bit index=0, block index=0, LFSR=seed, or 16'h0001 if seed=0; mode and k_cfg latched for the whole run.
REQ-019 valid=1 in the first RUN cycle, i.e. one cycle after start, presenting bit 0 of block 0.
REQ-020 A bit is accepted when valid&&ready; the bit index then increments; at M-1 it wraps to 0 and the block index increments.
REQ-021 While ready=0, rand, valid, block_start, block_end and all counters and LFSR state hold.
REQ-022 Per-block k is mode=0: latched k_cfg; mode=1: block index mod 6, via a 3-bit counter that wraps 5->0 with the block index, not a divider.
REQ-023 Pattern region is bits 0..10k-1; bit i is 1 when (i mod 10)<9, else 0, giving k runs of nine ones, each followed by a zero.
REQ-024 Random region is bits 10k..M-2; rand=LFSR[0], except it is forced 0 when the ones-run counter equals m-1=8.
REQ-025 Bit M-1 of every block is forced 0.
REQ-026 The ones-run counter is 4 bits; it increments on each accepted 1, clears on each accepted 0, and clears at block start.
REQ-027 Together, REQ-023..026 give exactly k non-overlapping and overlapping matches of the 9-ones template per block, with none across block boundaries.
REQ-028 LFSR is 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shift right with feedback into bit 15.
REQ-029 The LFSR advances only on an accepted bit in the random region, including forced-zero bits; it does not advance in the pattern region or on bit M-1.
REQ-030 start during RUN or DONE is ignored.
REQ-031 In IDLE and DONE: valid=0, rand=0, block_start=0, block_end=0.
REQ-032 busy=1 exactly in RUN; done=1 exactly in DONE.
REQ-033 Run length is N*M accepted bits, 1,032,000 at defaults; counters are 11 bits for the bit index and 10 bits for the block index.

Reset
REQ-034 rst forces IDLE and clears all outputs (rand, valid, block_start, block_end, busy, done) to 0.
REQ-035 rst also clears counters, ones-run counter and LFSR to 0, and takes priority over start and ready.
REQ-036 rst asserted mid-run aborts the run; no done pulse is issued and a fresh start is required.

Verification
REQ-037 mode=0, k_cfg=3, ready=1, M=1032, N=2: block 0 bits 0..29 = (1x9,0)x3; a reference 9-ones window counter reports 3 matches per block; done pulses once, 2064 cycles after start.
REQ-038 mode=1, N=12, ready=1: per-block match counts 0,1,2,3,4,5,0,1,2,3,4,5.
REQ-039 seed=0, k_cfg=0: behaviour identical to seed=16'h0001; no ones run exceeds 8; bit 1031 of every block is 0.
REQ-040 ready toggling on a pseudo-random 50% pattern, k_cfg=7: accepted bit stream identical to the ready=1 run with the same seed; outputs stable while ready=0.
REQ-041 rst asserted at block 1, bit 500: next cycle valid=0, busy=0, no done; start then replays from block 0 bit 0 with the same seed.
REQ-042 start pulsed during RUN: no effect on the stream; block_start and block_end each pulse exactly N times per run.
